// File: rtl/ahb_dual_port_ram_arbiter.sv
// Shares one single-port 32-bit RAM between the SCR1 imem (read-only) and dmem (R/W) AHB-Lite ports.
// Each port holds at most one pending request; the arbiter picks which one drives the RAM.

module ahb_ram_arb_port #(
  parameter int RAM_AW = 14
) (
  input  logic              cpu_clk,
  input  logic              pwrup_rst_n,
  input  logic              cap,
  input  logic              cap_ill,
  input  logic              cap_write,
  input  logic [RAM_AW+1:0] cap_addr,
  input  logic [1:0]        cap_size,
  input  logic              gnt,
  input  logic [31:0]       ram_rdata,
  output logic              hready,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              req,
  output logic              req_write,
  output logic [RAM_AW-1:0] req_addr,
  output logic [3:0]        req_be
);
  typedef enum logic [2:0] {IDLE, PEND, RDAT, ERR1, ERR2} st_t;

  st_t               st_q, st_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              wr_q, wr_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic              done, open;

  always_comb begin
    done   = (st_q == PEND && gnt && wr_q) || st_q == RDAT || st_q == ERR2;
    open   = (st_q == IDLE) || done;
    st_d   = st_q;
    addr_d = addr_q;
    off_d  = off_q;
    size_d = size_q;
    wr_d   = wr_q;
    case (st_q)
      PEND:    if (gnt && !wr_q) st_d = RDAT;
      ERR1:    st_d = ERR2;
      default: ;
    endcase
    // A new address phase can only land while idle or on the completing cycle.
    if (open) begin
      st_d = cap ? (cap_ill ? ERR1 : PEND) : IDLE;
      if (cap) begin
        addr_d = cap_addr[RAM_AW+1:2];
        off_d  = cap_addr[1:0];
        size_d = cap_size;
        wr_d   = cap_write;
      end
    end
    hready    = !((st_q == PEND && !done) || st_q == ERR1);
    hresp     = (st_q == ERR1) || (st_q == ERR2);
    hrdata    = (st_q == RDAT) ? ram_rdata : hrdata_q;
    hrdata_d  = hrdata;
    req       = (st_q == PEND);
    req_write = wr_q;
    req_addr  = addr_q;
    case (size_q)
      2'd0:    req_be = 4'b0001 << off_q;
      2'd1:    req_be = 4'b0011 << off_q;
      default: req_be = 4'hF;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      st_q     <= IDLE;
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      hrdata_q <= '0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      hrdata_q <= hrdata_d;
    end
  end
endmodule

module ahb_dual_port_ram_arbiter #(
  parameter int RAM_AW   = 14,
  parameter int ARB_MODE = 0
) (
  input  logic              cpu_clk,
  input  logic              pwrup_rst_n,
  input  logic              imem_hsel,
  input  logic [1:0]        imem_htrans,
  input  logic [31:0]       imem_haddr,
  output logic              imem_hready,
  output logic              imem_hresp,
  output logic [31:0]       imem_hrdata,
  input  logic              dmem_hsel,
  input  logic [1:0]        dmem_htrans,
  input  logic [31:0]       dmem_haddr,
  input  logic              dmem_hwrite,
  input  logic [2:0]        dmem_hsize,
  input  logic [31:0]       dmem_hwdata,
  input  logic              dmem_hready_in,
  output logic              dmem_hreadyout,
  output logic              dmem_hresp,
  output logic [31:0]       dmem_hrdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  logic              i_cap, i_ill, d_cap, d_ill;
  logic              i_req, d_req, i_wr_unused, d_wr, i_gnt, d_gnt;
  logic [RAM_AW-1:0] i_addr, d_addr;
  logic [3:0]        i_be, d_be;
  logic              last_d_q, last_d_d;
  logic              unused_bits;

  assign i_cap = imem_hsel & imem_htrans[1] & imem_hready;
  assign i_ill = |imem_haddr[1:0];
  assign d_cap = dmem_hsel & dmem_htrans[1] & dmem_hready_in;
  assign unused_bits = ^{imem_htrans[0], dmem_htrans[0], imem_haddr[31:RAM_AW+2],
                         dmem_haddr[31:RAM_AW+2], i_wr_unused};

  always_comb begin
    case (dmem_hsize)
      3'd0:    d_ill = 1'b0;
      3'd1:    d_ill = dmem_haddr[0];
      3'd2:    d_ill = |dmem_haddr[1:0];
      default: d_ill = 1'b1;
    endcase
  end

  ahb_ram_arb_port #(.RAM_AW(RAM_AW)) u_imem (
    .cpu_clk(cpu_clk), .pwrup_rst_n(pwrup_rst_n),
    .cap(i_cap), .cap_ill(i_ill), .cap_write(1'b0),
    .cap_addr(imem_haddr[RAM_AW+1:0]), .cap_size(2'd2),
    .gnt(i_gnt), .ram_rdata(ram_rdata),
    .hready(imem_hready), .hresp(imem_hresp), .hrdata(imem_hrdata),
    .req(i_req), .req_write(i_wr_unused), .req_addr(i_addr), .req_be(i_be)
  );

  ahb_ram_arb_port #(.RAM_AW(RAM_AW)) u_dmem (
    .cpu_clk(cpu_clk), .pwrup_rst_n(pwrup_rst_n),
    .cap(d_cap), .cap_ill(d_ill), .cap_write(dmem_hwrite),
    .cap_addr(dmem_haddr[RAM_AW+1:0]), .cap_size(dmem_hsize[1:0]),
    .gnt(d_gnt), .ram_rdata(ram_rdata),
    .hready(dmem_hreadyout), .hresp(dmem_hresp), .hrdata(dmem_hrdata),
    .req(d_req), .req_write(d_wr), .req_addr(d_addr), .req_be(d_be)
  );

  // last_d_q = 1 means dmem won the most recent conflict; reset favours dmem first.
  always_comb begin
    d_gnt     = d_req & (!i_req | (ARB_MODE == 1) | !last_d_q);
    i_gnt     = i_req & !d_gnt;
    last_d_d  = (i_req & d_req) ? d_gnt : last_d_q;
    ram_en    = i_gnt | d_gnt;
    ram_we    = d_gnt & d_wr;
    ram_be    = d_gnt ? d_be : (i_gnt ? i_be : 4'h0);
    ram_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
    ram_wdata = ram_we ? dmem_hwdata : 32'h0;
  end

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) last_d_q <= 1'b0;
    else              last_d_q <= last_d_d;
  end
endmodule
